// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared types for the two-port AXI read arbiter
package axi_rd_arb_pkg;

    localparam int ARB_ADDR_W = 40;
    localparam int ARB_ID_W   = 16;
    localparam int ARB_LEN_W  = 8;
    localparam int ARB_DATA_W = 128;
    localparam int ARB_USER_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_ID_W-1:0]   id;
        logic [ARB_LEN_W-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [ARB_USER_W-1:0] user;
    } ar_payload_t;

    // Remaining-beat counter steps down but parks at zero on overrun beats.
    function automatic logic [ARB_LEN_W-1:0] dec_sat(input logic [ARB_LEN_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rtl/axi_rd_arbiter_rr_arb2.sv - two-input round-robin arbiter, purely combinational
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       idx
);

    always_comb begin
        idx = 1'b0;
        if (req == 2'b11) begin
            idx = ptr;
        end else if (req[1]) begin
            idx = 1'b1;
        end
        gnt = (req != 2'b00) ? (2'b01 << idx) : 2'b00;
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one downstream AXI read port between two requesters
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int ID_W   = ARB_ID_W,
    parameter int LEN_W  = ARB_LEN_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int USER_W = ARB_USER_W
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,

    input  logic [ADDR_W-1:0] s0_axi_araddr,
    input  logic [ID_W-1:0]   s0_axi_arid,
    input  logic [LEN_W-1:0]  s0_axi_arlen,
    input  logic [2:0]        s0_axi_arsize,
    input  logic [1:0]        s0_axi_arburst,
    input  logic              s0_axi_arlock,
    input  logic [3:0]        s0_axi_arcache,
    input  logic [2:0]        s0_axi_arprot,
    input  logic [3:0]        s0_axi_arqos,
    input  logic [USER_W-1:0] s0_axi_aruser,
    input  logic              s0_axi_arvalid,
    output logic              s0_axi_arready,
    output logic [DATA_W-1:0] s0_axi_rdata,
    output logic [1:0]        s0_axi_rresp,
    output logic [ID_W-1:0]   s0_axi_rid,
    output logic              s0_axi_rlast,
    output logic              s0_axi_rvalid,
    input  logic              s0_axi_rready,

    input  logic [ADDR_W-1:0] s1_axi_araddr,
    input  logic [ID_W-1:0]   s1_axi_arid,
    input  logic [LEN_W-1:0]  s1_axi_arlen,
    input  logic [2:0]        s1_axi_arsize,
    input  logic [1:0]        s1_axi_arburst,
    input  logic              s1_axi_arlock,
    input  logic [3:0]        s1_axi_arcache,
    input  logic [2:0]        s1_axi_arprot,
    input  logic [3:0]        s1_axi_arqos,
    input  logic [USER_W-1:0] s1_axi_aruser,
    input  logic              s1_axi_arvalid,
    output logic              s1_axi_arready,
    output logic [DATA_W-1:0] s1_axi_rdata,
    output logic [1:0]        s1_axi_rresp,
    output logic [ID_W-1:0]   s1_axi_rid,
    output logic              s1_axi_rlast,
    output logic              s1_axi_rvalid,
    input  logic              s1_axi_rready,

    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [LEN_W-1:0]  m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic [USER_W-1:0] m_axi_aruser,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,

    output logic              busy,
    output logic              len_err,
    input  logic              len_err_clr
);

    state_t           state;
    logic             rr_ptr;
    logic             grant;
    ar_payload_t      ar_q;
    logic [LEN_W-1:0] beat_cnt;

    logic [1:0]       req;
    logic [1:0]       win_gnt;
    logic             win_idx;
    ar_payload_t      s0_pl;
    ar_payload_t      s1_pl;
    ar_payload_t      win_pl;
    logic             accept_ok;
    logic             in_data;
    logic             route0;
    logic             route1;
    logic             beat;
    logic             len_err_set;

    assign s0_pl = {s0_axi_araddr, s0_axi_arid, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst,
                    s0_axi_arlock, s0_axi_arcache, s0_axi_arprot, s0_axi_arqos, s0_axi_aruser};
    assign s1_pl = {s1_axi_araddr, s1_axi_arid, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst,
                    s1_axi_arlock, s1_axi_arcache, s1_axi_arprot, s1_axi_arqos, s1_axi_aruser};

    assign req = {s1_axi_arvalid, s0_axi_arvalid};

    rr_arb2 u_rr_arb2 (
        .req (req),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign win_pl = win_idx ? s1_pl : s0_pl;

    // Ready is gated by reset so a capture cannot be signalled on an edge that discards it.
    assign accept_ok      = (state == IDLE) && !s_axi_areset;
    assign s0_axi_arready = accept_ok & win_gnt[0];
    assign s1_axi_arready = accept_ok & win_gnt[1];

    assign busy = (state != IDLE);

    assign m_axi_araddr  = ar_q.addr;
    assign m_axi_arid    = ar_q.id;
    assign m_axi_arlen   = ar_q.len;
    assign m_axi_arsize  = ar_q.size;
    assign m_axi_arburst = ar_q.burst;
    assign m_axi_arlock  = ar_q.lock;
    assign m_axi_arcache = ar_q.cache;
    assign m_axi_arprot  = ar_q.prot;
    assign m_axi_arqos   = ar_q.qos;
    assign m_axi_aruser  = ar_q.user;

    assign in_data = (state == DATA);
    assign route0  = in_data & ~grant;
    assign route1  = in_data & grant;

    assign s0_axi_rvalid = route0 & m_axi_rvalid;
    assign s0_axi_rdata  = route0 ? m_axi_rdata : '0;
    assign s0_axi_rresp  = route0 ? m_axi_rresp : '0;
    assign s0_axi_rid    = route0 ? m_axi_rid   : '0;
    assign s0_axi_rlast  = route0 & m_axi_rlast;

    assign s1_axi_rvalid = route1 & m_axi_rvalid;
    assign s1_axi_rdata  = route1 ? m_axi_rdata : '0;
    assign s1_axi_rresp  = route1 ? m_axi_rresp : '0;
    assign s1_axi_rid    = route1 ? m_axi_rid   : '0;
    assign s1_axi_rlast  = route1 & m_axi_rlast;

    assign m_axi_rready = in_data & (grant ? s1_axi_rready : s0_axi_rready);

    assign beat = m_axi_rvalid & m_axi_rready;

    // RLAST must coincide exactly with the beat where the remaining count reaches zero.
    assign len_err_set = beat & (m_axi_rlast != (beat_cnt == '0));

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            grant         <= 1'b0;
            ar_q          <= '0;
            m_axi_arvalid <= 1'b0;
            beat_cnt      <= '0;
            len_err       <= 1'b0;
        end else begin
            if (len_err_set) begin
                len_err <= 1'b1;
            end else if (len_err_clr) begin
                len_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant         <= win_idx;
                        ar_q          <= win_pl;
                        beat_cnt      <= win_pl.len;
                        m_axi_arvalid <= 1'b1;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        beat_cnt <= dec_sat(beat_cnt);
                        if (m_axi_rlast) begin
                            rr_ptr <= ~grant;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

    localparam int AW = 40;
    localparam int IW = 16;
    localparam int LW = 8;
    localparam int DW = 128;
    localparam int UW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0][AW-1:0] araddr;
    logic [1:0][IW-1:0] arid;
    logic [1:0][LW-1:0] arlen;
    logic [1:0][2:0]    arsize;
    logic [1:0][1:0]    arburst;
    logic [1:0]         arlock;
    logic [1:0][3:0]    arcache;
    logic [1:0][2:0]    arprot;
    logic [1:0][3:0]    arqos;
    logic [1:0][UW-1:0] aruser;
    logic [1:0]         arvalid;
    logic [1:0]         arready;
    logic [1:0][DW-1:0] rdata;
    logic [1:0][1:0]    rresp;
    logic [1:0][IW-1:0] rid;
    logic [1:0]         rlast;
    logic [1:0]         rvalid;
    logic [1:0]         rready;

    logic [AW-1:0] m_araddr;
    logic [IW-1:0] m_arid;
    logic [LW-1:0] m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arlock;
    logic [3:0]    m_arcache;
    logic [2:0]    m_arprot;
    logic [3:0]    m_arqos;
    logic [UW-1:0] m_aruser;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic [IW-1:0] m_rid;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic          busy;
    logic          len_err;
    logic          len_err_clr;

    axi_rd_arbiter dut (
        .s_axi_aclk     (clk),
        .s_axi_areset   (rst),
        .s0_axi_araddr  (araddr[0]),
        .s0_axi_arid    (arid[0]),
        .s0_axi_arlen   (arlen[0]),
        .s0_axi_arsize  (arsize[0]),
        .s0_axi_arburst (arburst[0]),
        .s0_axi_arlock  (arlock[0]),
        .s0_axi_arcache (arcache[0]),
        .s0_axi_arprot  (arprot[0]),
        .s0_axi_arqos   (arqos[0]),
        .s0_axi_aruser  (aruser[0]),
        .s0_axi_arvalid (arvalid[0]),
        .s0_axi_arready (arready[0]),
        .s0_axi_rdata   (rdata[0]),
        .s0_axi_rresp   (rresp[0]),
        .s0_axi_rid     (rid[0]),
        .s0_axi_rlast   (rlast[0]),
        .s0_axi_rvalid  (rvalid[0]),
        .s0_axi_rready  (rready[0]),
        .s1_axi_araddr  (araddr[1]),
        .s1_axi_arid    (arid[1]),
        .s1_axi_arlen   (arlen[1]),
        .s1_axi_arsize  (arsize[1]),
        .s1_axi_arburst (arburst[1]),
        .s1_axi_arlock  (arlock[1]),
        .s1_axi_arcache (arcache[1]),
        .s1_axi_arprot  (arprot[1]),
        .s1_axi_arqos   (arqos[1]),
        .s1_axi_aruser  (aruser[1]),
        .s1_axi_arvalid (arvalid[1]),
        .s1_axi_arready (arready[1]),
        .s1_axi_rdata   (rdata[1]),
        .s1_axi_rresp   (rresp[1]),
        .s1_axi_rid     (rid[1]),
        .s1_axi_rlast   (rlast[1]),
        .s1_axi_rvalid  (rvalid[1]),
        .s1_axi_rready  (rready[1]),
        .m_axi_araddr   (m_araddr),
        .m_axi_arid     (m_arid),
        .m_axi_arlen    (m_arlen),
        .m_axi_arsize   (m_arsize),
        .m_axi_arburst  (m_arburst),
        .m_axi_arlock   (m_arlock),
        .m_axi_arcache  (m_arcache),
        .m_axi_arprot   (m_arprot),
        .m_axi_arqos    (m_arqos),
        .m_axi_aruser   (m_aruser),
        .m_axi_arvalid  (m_arvalid),
        .m_axi_arready  (m_arready),
        .m_axi_rdata    (m_rdata),
        .m_axi_rresp    (m_rresp),
        .m_axi_rid      (m_rid),
        .m_axi_rlast    (m_rlast),
        .m_axi_rvalid   (m_rvalid),
        .m_axi_rready   (m_rready),
        .busy           (busy),
        .len_err        (len_err),
        .len_err_clr    (len_err_clr)
    );

    logic [96:0] m_pl;
    assign m_pl = {m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
                   m_arlock, m_arcache, m_arprot, m_arqos, m_aruser};

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [96:0] s_pl(input int p);
        return {araddr[p], arid[p], arlen[p], arsize[p], arburst[p],
                arlock[p], arcache[p], arprot[p], arqos[p], aruser[p]};
    endfunction

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
        araddr[p]  = a;
        arid[p]    = 16'($urandom);
        arlen[p]   = l;
        arsize[p]  = 3'($urandom);
        arburst[p] = 2'($urandom);
        arlock[p]  = 1'($urandom);
        arcache[p] = 4'($urandom);
        arprot[p]  = 3'($urandom);
        arqos[p]   = 4'($urandom);
        aruser[p]  = 16'($urandom);
        arvalid[p] = 1'b1;
    endtask

    task automatic set_idle();
        araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0;
        arcache = '0; arprot = '0; arqos = '0; aruser = '0; arvalid = '0;
        rready = 2'b11;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rid = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        len_err_clr = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Starts in ADDR (just after capture); the burst ends with RLAST on beat index last_at.
    task automatic serve(input int p, input int last_at, input int ar_wait, input bit toggle,
                         input logic [96:0] epl);
        int i = 0;
        int budget = 0;
        for (int w = 0; w < ar_wait; w++) begin
            m_arready = 1'b0;
            #1;
            chk("addr_hold_valid", m_arvalid, 1);
            chk("addr_hold_payload", m_pl, epl);
            chk("addr_hold_no_arready", arready, 0);
            chk("addr_hold_busy", busy, 1);
            cyc();
        end
        m_arready = 1'b1;
        #1;
        chk("ar_valid", m_arvalid, 1);
        chk("ar_payload", m_pl, epl);
        cyc();
        m_arready = 1'b0;
        while (i <= last_at && budget < 200) begin
            m_rvalid  = toggle ? 1'($urandom) : 1'b1;
            rready[p] = toggle ? budget[0] : 1'b1;
            m_rlast   = (i == last_at);
            m_rdata   = {$urandom, $urandom, $urandom, $urandom};
            m_rid     = 16'($urandom);
            m_rresp   = 2'($urandom);
            #1;
            chk("ar_dropped", m_arvalid, 0);
            chk("data_no_arready", arready, 0);
            chk("r_valid_route", rvalid[p], m_rvalid);
            chk("r_data_route", rdata[p], m_rdata);
            chk("r_last_route", rlast[p], m_rlast);
            chk("r_id_route", rid[p], m_rid);
            chk("r_resp_route", rresp[p], m_rresp);
            chk("r_ready_mirror", m_rready, rready[p]);
            chk("r_other_valid", rvalid[1-p], 0);
            chk("r_other_data", rdata[1-p], 0);
            if (m_rvalid && rready[p]) i++;
            budget++;
            cyc();
        end
        chk("burst_budget", budget < 200, 1);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        rready   = 2'b11;
    endtask

    typedef struct {
        bit         pre_s0;
        logic [1:0] req;
        logic [1:0] exp_rdy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [96:0] epl;
        vecs[0] = '{0, 2'b01, 2'b01};
        vecs[1] = '{0, 2'b10, 2'b10};
        vecs[2] = '{0, 2'b11, 2'b01};
        vecs[3] = '{1, 2'b11, 2'b10};
        vecs[4] = '{1, 2'b01, 2'b01};
        vecs[5] = '{0, 2'b00, 2'b00};

        do_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_payload", m_pl, 0);
        chk("rst_arready", arready, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rready", m_rready, 0);

        // s0 alone, 4-beat burst at 0x1000.
        cyc();
        set_req(0, 40'h1000, 8'd3);
        #1;
        chk("t1_arready", arready, 2'b01);
        epl = s_pl(0);
        cyc();
        arvalid[0] = 1'b0;
        araddr[0]  = 40'hdead;
        chk("t1_m_araddr", m_araddr, 40'h1000);
        serve(0, 3, 0, 0, epl);
        chk("t1_idle", busy, 0);
        chk("t1_no_err", len_err, 0);

        // Arbitration table.
        foreach (vecs[k]) begin
            int w;
            do_reset();
            if (vecs[k].pre_s0) begin
                set_req(0, 40'h40, 8'd0);
                epl = s_pl(0);
                cyc();
                arvalid[0] = 1'b0;
                serve(0, 0, 0, 0, epl);
            end
            for (int p = 0; p < 2; p++) begin
                if (vecs[k].req[p]) set_req(p, 40'(64'h100 * (p + 1) + k), 8'd0);
            end
            #1;
            chk($sformatf("vec%0d_arready", k), arready, vecs[k].exp_rdy);
            w = vecs[k].exp_rdy[1] ? 1 : 0;
            epl = s_pl(w);
            cyc();
            arvalid = '0;
            if (vecs[k].exp_rdy != 2'b00) begin
                chk($sformatf("vec%0d_addr", k), m_araddr, 40'(64'h100 * (w + 1) + k));
                serve(w, 0, 0, 0, epl);
            end else begin
                chk($sformatf("vec%0d_idle", k), busy, 0);
            end
        end

        // Tie after reset: s0, then waiting s1, then next tie goes to s0.
        do_reset();
        set_req(0, 40'hA00, 8'd1);
        set_req(1, 40'hB00, 8'd2);
        #1;
        chk("tie1_arready", arready, 2'b01);
        epl = s_pl(0);
        cyc();
        arvalid[0] = 1'b0;
        serve(0, 1, 0, 0, epl);
        #1;
        chk("tie2_arready", arready, 2'b10);
        epl = s_pl(1);
        cyc();
        arvalid[1] = 1'b0;
        serve(1, 2, 0, 0, epl);
        set_req(0, 40'hC00, 8'd0);
        set_req(1, 40'hD00, 8'd0);
        #1;
        chk("tie3_arready", arready, 2'b01);
        epl = s_pl(0);
        cyc();
        arvalid[0] = 1'b0;
        serve(0, 0, 5, 0, epl);
        arvalid[1] = 1'b0;

        // Downstream ready held off, then rready toggling.
        set_req(1, 40'h3000, 8'd4);
        epl = s_pl(1);
        cyc();
        arvalid[1] = 1'b0;
        serve(1, 4, 5, 1, epl);
        chk("toggle_no_err", len_err, 0);

        // Early RLAST flags len_err; clear it afterwards.
        set_req(0, 40'h4000, 8'd3);
        epl = s_pl(0);
        cyc();
        arvalid[0] = 1'b0;
        serve(0, 2, 0, 0, epl);
        chk("early_len_err", len_err, 1);
        chk("early_idle", busy, 0);
        len_err_clr = 1'b1;
        cyc();
        len_err_clr = 1'b0;
        chk("clr_len_err", len_err, 0);

        // Late RLAST on a single-beat burst.
        set_req(1, 40'h5000, 8'd0);
        epl = s_pl(1);
        cyc();
        arvalid[1] = 1'b0;
        serve(1, 1, 0, 0, epl);
        chk("late_len_err", len_err, 1);

        // Reset in the middle of a burst.
        set_req(1, 40'h6000, 8'd3);
        cyc();
        arvalid[1] = 1'b0;
        m_arready  = 1'b1;
        cyc();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        #1;
        chk("mid_rvalid", rvalid[1], 1);
        rst = 1'b1;
        arvalid[0] = 1'b1;
        cyc();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_arvalid", m_arvalid, 0);
        chk("mid_rst_payload", m_pl, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rready", m_rready, 0);
        chk("mid_rst_len_err", len_err, 0);
        chk("mid_rst_arready", arready, 0);
        do_reset();

        // Randomized traffic against a transaction-level reference.
        begin
            int         phase;
            int         g;
            int         last_srv;
            int         win;
            int         beat_i;
            int         elen;
            int         tgt;
            int         bursts;
            bit         eerr;
            bit         nerr;
            bit [1:0]   pend;
            logic [1:0] ea;
            phase = 0; g = 0; last_srv = 1; beat_i = 0; elen = 0; tgt = 0;
            bursts = 0; eerr = 1'b0; pend = 2'b00;
            for (int c = 0; c < 4000; c++) begin
                for (int p = 0; p < 2; p++) begin
                    arvalid[p] = pend[p];
                    if (!pend[p] && ($urandom % 4 == 0)) begin
                        set_req(p, {8'h0, $urandom}, 8'($urandom_range(0, 5)));
                        pend[p] = 1'b1;
                    end
                end
                m_arready   = ($urandom % 3 == 0);
                rready[0]   = ($urandom % 4 != 0);
                rready[1]   = ($urandom % 4 != 0);
                len_err_clr = ($urandom % 16 == 0);
                m_rdata     = {$urandom, $urandom, $urandom, $urandom};
                m_rid       = 16'($urandom);
                m_rresp     = 2'($urandom);
                if (phase == 2) begin
                    m_rvalid = ($urandom % 4 != 0);
                    m_rlast  = (beat_i == tgt);
                end else begin
                    m_rvalid = 1'($urandom);
                    m_rlast  = 1'($urandom);
                end
                #1;
                win = -1;
                if (pend == 2'b11) win = 1 - last_srv;
                else if (pend[0]) win = 0;
                else if (pend[1]) win = 1;
                ea = (phase == 0 && win >= 0) ? (2'b01 << win) : 2'b00;
                chk("rnd_arready", arready, ea);
                chk("rnd_busy", busy, phase != 0);
                chk("rnd_len_err", len_err, eerr);
                chk("rnd_arvalid", m_arvalid, phase == 1);
                if (phase == 1) chk("rnd_payload", m_pl, epl);
                if (phase == 2) begin
                    chk("rnd_rvalid", rvalid[g], m_rvalid);
                    chk("rnd_rdata", rdata[g], m_rdata);
                    chk("rnd_rready", m_rready, rready[g]);
                    chk("rnd_other", {rvalid[1-g], rdata[1-g]}, 0);
                end else begin
                    chk("rnd_rvalid_idle", rvalid, 0);
                    chk("rnd_rready_idle", m_rready, 0);
                end
                nerr = len_err_clr ? 1'b0 : eerr;
                case (phase)
                    0: if (win >= 0) begin
                        g       = win;
                        epl     = s_pl(g);
                        elen    = int'(arlen[g]);
                        beat_i  = 0;
                        pend[g] = 1'b0;
                        case ($urandom % 8)
                            0:       tgt = (elen > 0) ? elen - 1 : elen + 1;
                            1:       tgt = elen + 1;
                            default: tgt = elen;
                        endcase
                        phase = 1;
                    end
                    1: if (m_arready) phase = 2;
                    default: if (m_rvalid && rready[g]) begin
                        if (m_rlast != (beat_i >= elen)) nerr = 1'b1;
                        if (m_rlast) begin
                            phase    = 0;
                            last_srv = g;
                            bursts++;
                        end else begin
                            beat_i++;
                        end
                    end
                endcase
                eerr = nerr;
                cyc();
            end
            chk("rnd_bursts_done", bursts > 20, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
